layer1_pool: RTL and testbench

LAYER1_POOL -- requirements
Module: layer1_pool

---
 rtl/layer1_pool.sv | 158 +++++++++++++++
 tb/tb_layer1_pool.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/layer1_pool.sv
// 2x2 max-pool stage behind layer0. Each conv sample is written straight to L0 memory.
// Each 2x2 block maximum is queued in a one-entry slot and written to L1 memory when the write port is free.
module layer1_pool #(
    parameter int DW = 19
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_start,
    input  logic          i_valid,
    input  logic [DW-1:0] i_data,
    output logic          o_busy,
    output logic          o_we,
    output logic          o_csel,
    output logic [11:0]   o_addr,
    output logic [DW-1:0] o_data,
    output logic          o_done,
    output logic          o_err,
    output logic [1:0]    o_dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    g_q, g_d;
    logic [4:0]    c_q, c_d;
    logic [4:0]    rp_q, rp_d;
    logic          pend_q, pend_d;
    logic [9:0]    pend_addr_q, pend_addr_d;
    logic [DW-1:0] pend_max_q, pend_max_d;
    logic [DW-1:0] max_q, max_d;
    logic [DW-1:0] cand;
    logic          busy_q, busy_d;
    logic          we_q, we_d;
    logic          csel_q, csel_d;
    logic [11:0]   addr_q, addr_d;
    logic [DW-1:0] data_q, data_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    always_comb begin
        // g0 restarts the running max; on ties the held value wins
        cand        = (g_q != 2'd0 && max_q >= i_data) ? max_q : i_data;
        state_d     = state_q;
        g_d         = g_q;
        c_d         = c_q;
        rp_d        = rp_q;
        pend_d      = pend_q;
        pend_addr_d = pend_addr_q;
        pend_max_d  = pend_max_q;
        max_d       = max_q;
        busy_d      = busy_q;
        we_d        = 1'b0;
        csel_d      = csel_q;
        addr_d      = addr_q;
        data_d      = data_q;
        done_d      = 1'b0;
        err_d       = err_q;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d = RUN;
                    busy_d  = 1'b1;
                    g_d     = 2'd0;
                    c_d     = 5'd0;
                    rp_d    = 5'd0;
                    pend_d  = 1'b0;
                    err_d   = 1'b0;
                    max_d   = '0;
                end
            end
            RUN: begin
                if (i_valid) begin
                    we_d   = 1'b1;
                    csel_d = 1'b0;
                    addr_d = {rp_q, g_q[0], c_q, g_q[1]};
                    data_d = i_data;
                    max_d  = cand;
                    g_d    = g_q + 2'd1;
                    if (g_q == 2'd3) begin
                        // An unissued older max is lost here; the stream never stalls
                        if (pend_q) err_d = 1'b1;
                        pend_d      = 1'b1;
                        pend_max_d  = cand;
                        pend_addr_d = {rp_q, c_q};
                        c_d         = c_q + 5'd1;
                        if (c_q == 5'd31) rp_d = rp_q + 5'd1;
                    end
                end else if (pend_q) begin
                    we_d   = 1'b1;
                    csel_d = 1'b1;
                    addr_d = {2'b00, pend_addr_q};
                    data_d = pend_max_q;
                    pend_d = 1'b0;
                    if (pend_addr_q == 10'd1023) state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                g_d     = 2'd0;
                c_d     = 5'd0;
                rp_d    = 5'd0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            g_q         <= 2'd0;
            c_q         <= 5'd0;
            rp_q        <= 5'd0;
            pend_q      <= 1'b0;
            pend_addr_q <= 10'd0;
            pend_max_q  <= '0;
            max_q       <= '0;
            busy_q      <= 1'b0;
            we_q        <= 1'b0;
            csel_q      <= 1'b0;
            addr_q      <= 12'd0;
            data_q      <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            g_q         <= g_d;
            c_q         <= c_d;
            rp_q        <= rp_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
            pend_max_q  <= pend_max_d;
            max_q       <= max_d;
            busy_q      <= busy_d;
            we_q        <= we_d;
            csel_q      <= csel_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign o_busy      = busy_q;
    assign o_we        = we_q;
    assign o_csel      = csel_q;
    assign o_addr      = addr_q;
    assign o_data      = data_q;
    assign o_done      = done_q;
    assign o_err       = err_q;
    assign o_dbg_state = state_q;

endmodule

// File: tb/tb_layer1_pool.sv
// Randomized bench for layer1_pool: a frame-level reference model fills expected L0/L1 write queues,
// and a monitor pops and compares them whenever the DUT issues a write.
module tb_layer1_pool;
    localparam int DW = 19;
    localparam int W  = 12 + DW;

    logic          clk = 1'b0;
    logic          reset;
    logic          i_start;
    logic          i_valid;
    logic [DW-1:0] i_data;
    logic          o_busy, o_we, o_csel, o_done, o_err;
    logic [11:0]   o_addr;
    logic [DW-1:0] o_data;
    logic [1:0]    o_dbg_state;

    layer1_pool #(.DW(DW)) dut (
        .clk(clk), .reset(reset), .i_start(i_start), .i_valid(i_valid), .i_data(i_data),
        .o_busy(o_busy), .o_we(o_we), .o_csel(o_csel), .o_addr(o_addr), .o_data(o_data),
        .o_done(o_done), .o_err(o_err), .o_dbg_state(o_dbg_state)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    logic [W-1:0] exp_l0_q[$];
    logic [W-1:0] exp_l1_q[$];
    int l0_cnt = 0;
    int l1_cnt = 0;
    int done_cnt = 0;
    logic [11:0] last_l1_addr = 12'd0;

    // Frame-level reference: sample index -> pixel position, block max, one-slot L1 pending entry
    int mdl_n;
    logic [DW-1:0] mdl_bmax;
    logic mdl_pend;
    logic [W-1:0] mdl_pend_item;
    logic mdl_err;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (o_we) begin
            if (o_csel) begin
                l1_cnt++;
                last_l1_addr = o_addr;
                if (exp_l1_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL l1_unexpected: got addr %0d data %0h, required no write", o_addr, o_data);
                end else chk("l1_write", {o_addr, o_data}, exp_l1_q.pop_front());
            end else begin
                l0_cnt++;
                if (exp_l0_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL l0_unexpected: got addr %0d data %0h, required no write", o_addr, o_data);
                end else chk("l0_write", {o_addr, o_data}, exp_l0_q.pop_front());
            end
        end
        if (o_done) begin
            done_cnt++;
            chk("busy_low_at_done", o_busy, 1'b0);
        end
    end

    task automatic model_clear();
        mdl_n = 0; mdl_bmax = '0; mdl_pend = 1'b0; mdl_pend_item = '0; mdl_err = 1'b0;
    endtask

    task automatic model_sample(input logic [DW-1:0] d);
        int blk, g, row, col;
        blk = mdl_n / 4;
        g   = mdl_n % 4;
        row = 2 * (blk / 32) + (g % 2);
        col = 2 * (blk % 32) + (g / 2);
        exp_l0_q.push_back({12'(row * 64 + col), d});
        if (g == 0 || d > mdl_bmax) mdl_bmax = d;
        if (g == 3) begin
            if (mdl_pend) mdl_err = 1'b1;
            mdl_pend = 1'b1;
            mdl_pend_item = {12'(blk), mdl_bmax};
        end
        mdl_n = (mdl_n + 1) % 4096;
    endtask

    // An input cycle without a sample frees the write port for the pending L1 entry
    task automatic model_gap();
        if (mdl_pend) begin
            exp_l1_q.push_back(mdl_pend_item);
            mdl_pend = 1'b0;
        end
    endtask

    task automatic send(input logic [DW-1:0] d);
        @(negedge clk);
        i_valid = 1'b1;
        i_data  = d;
        model_sample(d);
    endtask

    task automatic idle(input int k);
        repeat (k) begin
            @(negedge clk);
            i_valid = 1'b0;
            model_gap();
        end
    endtask

    task automatic start_frame();
        @(negedge clk);
        i_valid = 1'b0;
        i_start = 1'b1;
        model_clear();
        @(negedge clk);
        i_start = 1'b0;
    endtask

    task automatic do_reset(input string name);
        @(negedge clk);
        reset   = 1'b1;
        i_valid = 1'b0;
        i_start = 1'b0;
        #1;
        chk(name, {o_busy, o_we, o_csel, o_addr, o_data, o_done, o_err}, '0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk({name, "_queues_drained"}, exp_l0_q.size() + exp_l1_q.size(), 0);
        exp_l0_q.delete();
        exp_l1_q.delete();
        model_clear();
    endtask

    function automatic logic [DW-1:0] rnd_data();
        if ($urandom_range(0, 3) == 0) return DW'($urandom_range(0, 3));
        return DW'($urandom_range(0, (1 << DW) - 1));
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, l0b, l1b;
        logic [DW-1:0] v;
        reset = 1'b1; i_start = 1'b0; i_valid = 1'b0; i_data = '0;
        model_clear();
        do_reset("reset_state");

        // Basic block: 5,9,3,7 two cycles apart
        start_frame();
        chk("busy_after_start", o_busy, 1'b1);
        send(5); idle(1); send(9); idle(1); send(3); idle(1); send(7); idle(1);
        chk("a_l0_last", {o_we, o_csel, o_addr, o_data}, {1'b1, 1'b0, 12'd65, DW'(7)});
        idle(1);
        chk("a_l1", {o_we, o_csel, o_addr, o_data}, {1'b1, 1'b1, 12'd0, DW'(9)});
        idle(2);
        chk("a_err", o_err, 1'b0);

        // Full-scale block at rp=1, c=2 after 34 random blocks
        do_reset("reset_b");
        start_frame();
        for (int i = 0; i < 136; i++) begin
            send(rnd_data());
            idle($urandom_range(0, 2));
        end
        idle(2);
        send(DW'(19'h7FFFF)); idle(1);
        chk("b_addr0", o_addr, 12'd132);
        send(0); idle(1);
        chk("b_addr1", o_addr, 12'd196);
        send(0); idle(1);
        chk("b_addr2", o_addr, 12'd133);
        send(DW'(19'h7FFFF)); idle(1);
        chk("b_addr3", o_addr, 12'd197);
        idle(1);
        chk("b_l1", {o_we, o_csel, o_addr, o_data}, {1'b1, 1'b1, 12'd34, DW'(19'h7FFFF)});
        idle(2);
        chk("b_err", o_err, mdl_err);

        // g0 directly behind g3: L0 first, L1 one cycle later
        do_reset("reset_c");
        start_frame();
        send(rnd_data()); idle(1); send(rnd_data()); idle(1); send(rnd_data()); idle(1);
        send(rnd_data());
        send(rnd_data());
        chk("c_g3_l0", {o_we, o_csel, o_addr}, {1'b1, 1'b0, 12'd65});
        idle(1);
        chk("c_g0_l0", {o_we, o_csel, o_addr}, {1'b1, 1'b0, 12'd2});
        idle(1);
        chk("c_l1_late", {o_we, o_csel, o_addr}, {1'b1, 1'b1, 12'd0});
        chk("c_err", o_err, 1'b0);
        idle(2);

        // Two blocks back to back: first max overwritten, overrun flagged
        do_reset("reset_d");
        start_frame();
        l1b = l1_cnt;
        for (int i = 0; i < 8; i++) send(rnd_data());
        idle(3);
        chk("d_err", o_err, 1'b1);
        chk("d_l1_count", l1_cnt - l1b, 1);

        // Reset mid-frame after 10 samples, early samples dropped, new frame restarts at 0
        do_reset("reset_e0");
        start_frame();
        for (int i = 0; i < 10; i++) begin
            send(rnd_data());
            idle(1);
        end
        idle(2);
        do_reset("e_midframe_reset");
        chk("e_busy_after_reset", o_busy, 1'b0);
        @(negedge clk); i_valid = 1'b1; i_data = DW'(123);
        @(negedge clk); i_valid = 1'b0;
        idle(2);
        chk("e_no_write_before_start", o_we, 1'b0);
        start_frame();
        v = rnd_data();
        send(v); idle(1);
        chk("e_restart_addr", {o_we, o_csel, o_addr, o_data}, {1'b1, 1'b0, 12'd0, v});
        send(rnd_data()); send(rnd_data()); send(rnd_data()); idle(2);

        // Full raster
        do_reset("reset_f");
        start_frame();
        d0 = done_cnt; l0b = l0_cnt; l1b = l1_cnt;
        for (int n = 0; n < 4096; n++) begin
            send(rnd_data());
            idle((n % 4 == 3) ? $urandom_range(1, 2) : $urandom_range(0, 1));
        end
        for (int k = 0; k < 50 && done_cnt == d0; k++) @(negedge clk);
        repeat (5) @(negedge clk);
        chk("f_done_pulses", done_cnt - d0, 1);
        chk("f_l0_count", l0_cnt - l0b, 4096);
        chk("f_l1_count", l1_cnt - l1b, 1024);
        chk("f_last_l1_addr", last_l1_addr, 12'd1023);
        chk("f_busy_after", o_busy, 1'b0);
        chk("f_err", o_err, 1'b0);
        chk("f_queues_empty", exp_l0_q.size() + exp_l1_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
